// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering one load/store at a time with a fixed number of wait states.
// Optional build macro DMEM_MISALIGN_ERR_EN: reject misaligned half/word accesses with rsp_err.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;

    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_op_write;
    logic [31:0]      w_op_addr;
    logic [31:0]      w_op_wdata;
    logic [1:0]       w_op_size;
    logic             w_op_unsigned;
    logic             w_oob;
    logic             w_misalign;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_old_word;
    logic [31:0]      w_load_data;
    logic [31:0]      w_new_word;
    logic             w_mem_we;

    // Pick the addressed byte/half lane and extend it to 32 bits.
    function automatic logic [31:0] ext_load(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic [31:0]        res;
        sb = word[{lane, 3'b000} +: 8];
        sh = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? {24'h0, sb} : {{24{sb[7]}}, sb};
            2'b01:   res = uns ? {16'h0, sh} : {{16{sh[15]}}, sh};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign req_ready = rst && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    // With no wait states the response is formed on the accepting edge, straight from the request inputs.
    assign w_op_write    = (r_state == IDLE) ? req_write    : r_write;
    assign w_op_addr     = (r_state == IDLE) ? req_addr     : r_addr;
    assign w_op_wdata    = (r_state == IDLE) ? req_wdata    : r_wdata;
    assign w_op_size     = (r_state == IDLE) ? req_size     : r_size;
    assign w_op_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;

    assign w_enter_resp = ((r_state == IDLE) && w_accept && NO_WAIT) ||
                          ((r_state == WAIT) && (r_cnt == 4'd1));

    assign w_oob = (w_op_addr[31:2] >= 30'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = ((w_op_size == 2'b01) && w_op_addr[0]) ||
                        (w_op_size[1] && (w_op_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err       = w_oob || w_misalign;
    assign w_idx       = w_op_addr[IDX_W+1:2];
    assign w_old_word  = r_mem[w_idx];
    assign w_load_data = ext_load(w_old_word, w_op_addr[1:0], w_op_size, w_op_unsigned);
    assign w_new_word  = merge_store(w_old_word, w_op_wdata, w_op_addr[1:0], w_op_size);
    assign w_mem_we    = w_enter_resp && w_op_write && !w_err;

    // Request capture; accept is already gated by reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end
    end

    // Storage is never reset; a store lands only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_new_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (NO_WAIT) begin
                            r_state   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= w_err;
                            rsp_rdata <= (w_err || w_op_write) ? 32'h0 : w_load_data;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state   <= RESP;
                        r_cnt     <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= w_err;
                        rsp_rdata <= (w_err || w_op_write) ? 32'h0 : w_load_data;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state   <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= 4'd0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, randomized and directed accesses,
// plus a zero-wait-state instance for latency.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_write = 1'b0;
    logic [31:0] z_req_addr = 32'h0;
    logic [31:0] z_req_wdata = 32'h0;
    logic [1:0]  z_req_size = 2'b00;
    logic        z_req_unsigned = 1'b0;
    logic        z_rsp_valid;
    logic        z_rsp_ready = 1'b1;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .req_size(z_req_size), .req_unsigned(z_req_unsigned), .rsp_valid(z_rsp_valid),
        .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mdl_b [0:4*DEPTH-1];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          mode = 0;

    always #5 clk = ~clk;

    initial begin : cyc_counter
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin : rdy_driver
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference: memory as little-endian bytes; an access touches 1, 2 or 4 bytes from its aligned base.
    function automatic void mdl_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz, input logic u,
                                      output logic [31:0] rd, output logic e);
        int          n;
        logic [31:0] base;
        logic [31:0] v;
        logic        mis;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = a & ~(32'(n) - 32'd1);
        mis  = MIS_EN && (base != a);
        e    = mis || ({32'h0, a} >= 64'(4 * DEPTH));
        rd   = 32'h0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < n; i++) mdl_b[int'(base) + i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl_b[int'(base) + i]) << (8 * i));
                if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endfunction

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic u, output logic [31:0] exp_d);
        int          t;
        logic [31:0] rd;
        logic        e;
        req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
        req_valid = 1'b1;
        t = 0;
        exp_d = 32'h0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            t++;
            if (t > 200) break;
        end
        if (t > 200) begin
            n_chk++; n_fail++;
            $display("FAIL req_accept_timeout: req_ready stayed 0, expected 1 within 200 cycles");
        end else begin
            mdl_apply(w, a, d, sz, u, rd, e);
            exp_d = rd;
            sbq.push_back('{rdata: rd, err: e, acc: cyc + 1});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || rsp_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        bit   checked;
        exp_t e;
        checked = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid && !checked) begin
                checked = 1'b1;
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response pending");
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(WAITC + 1));
                end
            end
            if (rsp_valid && rsp_ready) checked = 1'b0;
        end
    end

    task automatic z_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic u, input logic [31:0] exp_d);
        int t;
        int acc;
        z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_size = sz; z_req_unsigned = u;
        z_req_valid = 1'b1;
        t = 0;
        while (!z_req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!z_req_ready) @(negedge clk);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (z_rsp_valid || t > 50) break;
            t++;
        end
        chk("z_rsp_valid", {31'h0, z_rsp_valid}, 32'h1);
        chk("z_latency", 32'(cyc - acc + 1), 32'h1);
        chk("z_rsp_rdata", z_rsp_rdata, exp_d);
        chk("z_rsp_err", {31'h0, z_rsp_err}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] xd;
        logic [31:0] a;
        int          t;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) do_req(1'b1, 32'(4 * i), $urandom, 2'b10, 1'b0, xd);

        // Word store/load, then byte merge with signed/unsigned reads.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, xd);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, xd);
        do_req(1'b1, 32'h11, 32'h00000080, 2'b00, 1'b0, xd);
        do_req(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, xd);
        do_req(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, xd);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, xd);
        do_req(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, xd);
        do_req(1'b1, 32'h22, 32'h12345678, 2'b10, 1'b0, xd);
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, xd);
        do_req(1'b1, 32'h402, 32'h0000FFFF, 2'b01, 1'b0, xd);
        do_req(1'b0, 32'h13, 32'h0, 2'b01, 1'b0, xd);
        drain();

        // Backpressure: response must hold while a second request is offered and ignored.
        mode = 2;
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, xd);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            req_write = 1'b1; req_addr = 32'h50; req_wdata = 32'hA5A5A5A5;
            req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
            @(negedge clk);
            chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("hold_rsp_rdata", rsp_rdata, xd);
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mode = 0;
        drain();
        do_req(1'b0, 32'h50, 32'h0, 2'b10, 1'b0, xd);
        drain();

        // Reset during the wait states of a store: nothing may be committed.
        req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
        req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (req_ready || t > 50) break;
            t++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_mid_req_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, xd);
        drain();

        // Randomized traffic with random response backpressure.
        mode = 1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
                if (a < 32'h400) a = a + 32'h400;
            end else begin
                a = 32'($urandom_range(0, 127));
            end
            do_req(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), xd);
        end
        drain();
        mode = 0;
        for (int i = 0; i < 32; i++) do_req(1'b0, 32'(4 * i), 32'h0, 2'b10, 1'b0, xd);
        drain();

        // Zero wait states: response visible one cycle after accept.
        z_req(1'b1, 32'h40, 32'h0BADCAFE, 2'b10, 1'b0, 32'h0);
        z_req(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h0BADCAFE);
        z_req(1'b0, 32'h42, 32'h0, 2'b01, 1'b0, 32'h00000BAD);
        z_req(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 32'hFFFFFFFE);
        z_req(1'b0, 32'h40, 32'h0, 2'b00, 1'b1, 32'h000000FE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of added wait states per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  the core presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-012 SHALL have port rsp_valid  output  1  a response is presented.
REQ-013 SHALL have port rsp_ready  input  1  the core accepts the response.
REQ-014 SHALL have port rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  the access was rejected; no storage changed.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL assert req_ready only in IDLE with rst high; all other outputs SHALL be registered.
REQ-018 SHALL, on req_valid&req_ready at an edge in IDLE, latch write, addr, wdata, size and unsigned, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-019 SHALL decrement the counter each WAIT cycle and leave WAIT for RESP on the edge where the counter is 1.
REQ-020 SHALL assert rsp_valid exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 SHALL commit a store to storage on the edge entering RESP, so a subsequent load observes it.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1; on that edge it SHALL clear rsp_valid and return to IDLE.
REQ-023 SHALL support one outstanding request; throughput SHALL be at most one access per WAIT_CYCLES+2 cycles.
REQ-024 SHALL use word index = addr[31:2]; addr >= 4*DEPTH_WORDS SHALL give rsp_err=1, no write and rsp_rdata=0.
REQ-025 SHALL select the load byte lane by addr[1:0] and the half lane by addr[1], then sign- or zero-extend to 32 bits per req_unsigned.
REQ-026 SHALL, for a store, merge only the addressed byte or half lanes into the existing word and leave the other lanes unchanged.
REQ-027 SHALL ignore req_valid while not in IDLE, with no side effect.

Reset
REQ-028 SHALL, while rst=0, force state to IDLE, rsp_valid to 0, rsp_rdata to 0, rsp_err to 0, the counter to 0 and req_ready to 0.
REQ-029 SHALL abandon any uncommitted store when rst asserts mid-access; a store already committed SHALL remain.
REQ-030 SHALL NOT reset storage contents.

Configuration
REQ-031 SHALL, with DMEM_MISALIGN_ERR_EN defined, reject a half access with addr[0]=1 and a word access with addr[1:0]!=0 with rsp_err=1, no write, rsp_rdata=0, and the same latency as a normal access.
REQ-032 SHALL, without DMEM_MISALIGN_ERR_EN, never flag misalignment: a half access SHALL use addr[1] only, a word access SHALL ignore addr[1:0], and rsp_err SHALL come only from the REQ-024 range check.

Verification
REQ-033 SHALL test: WAIT_CYCLES=2, store word 0xDEADBEEF to 0x10 then load word from 0x10 -> rsp_valid 3 cycles after each accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-034 SHALL test: after REQ-033, store byte 0x80 to 0x11, then load signed byte 0x11 and unsigned byte 0x11 -> 0xFFFFFF80 then 0x00000080; load word 0x10 -> 0xDEAD80EF.
REQ-035 SHALL test: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable throughout, req_ready=0, a second req_valid is ignored.
REQ-036 SHALL test: load from address 4*DEPTH_WORDS=0x400 -> rsp_err=1, rsp_rdata=0.
REQ-037 SHALL test: word store 0x12345678 to 0x22 -> with the macro, rsp_err=1 and word 0x20 unchanged; without it, word 0x20=0x12345678.
REQ-038 SHALL test: rst pulsed low during WAIT of a store to 0x30 -> rsp_valid=0, state IDLE, word 0x30 unchanged; WAIT_CYCLES=0 run -> rsp_valid 1 cycle after accept.
